fp32_to_bf16: RTL and testbench



---
 rtl/fp32_to_bf16.sv | 191 +++++++++++++++++++
 tb/tb_fp32_to_bf16.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_bf16.sv
// fp32_to_bf16: two-stage valid/ready FP32 -> BF16 narrowing converter.
// Rounds to nearest-even, reports {NV, OF, UF, NX} per result and keeps
// a sticky copy of those flags that only accumulates on output handshakes.
module fp32_to_bf16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] operand_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [3:0]  flags,
  input  logic        fpcsr_clear,
  output logic [3:0]  fpcsr
);

  typedef enum logic [1:0] {
    KIND_FINITE = 2'd0,
    KIND_ZERO   = 2'd1,
    KIND_INF    = 2'd2,
    KIND_NAN    = 2'd3
  } kind_t;

  localparam logic [15:0] QNAN_BF16 = 16'h7FC0;

  // Flag bit positions inside the 4-bit flag vector.
  localparam int NV_BIT = 3;
  localparam int OF_BIT = 2;
  localparam int UF_BIT = 1;
  localparam int NX_BIT = 0;

  // ---------------------------------------------------------------------
  // Handshake / stall control
  // ---------------------------------------------------------------------
  logic s1_valid_q;
  logic s2_valid_q;
  logic s1_adv;
  logic s2_adv;
  logic out_hs;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_hs    = s2_valid_q && out_ready;

  // ---------------------------------------------------------------------
  // Stage 1: classify the operand and derive the rounding terms
  // ---------------------------------------------------------------------
  logic [7:0]  in_exp;
  logic [22:0] in_man;
  kind_t       s1_kind_d;
  logic        s1_round_up_d;
  logic        s1_nx_d;

  assign in_exp = operand_a[30:23];
  assign in_man = operand_a[22:0];

  // Decode the operand class and the round-to-nearest-even increment.
  always_comb begin
    logic lsb;
    logic guard;
    logic sticky;
    lsb    = operand_a[16];
    guard  = operand_a[15];
    sticky = |operand_a[14:0];

    s1_round_up_d = guard && (sticky || lsb);
    s1_nx_d       = guard || sticky;

    if (in_exp == 8'hFF) begin
      s1_kind_d = (in_man != 23'd0) ? KIND_NAN : KIND_INF;
    end else if ((in_exp == 8'h00) && (in_man == 23'd0)) begin
      s1_kind_d = KIND_ZERO;
    end else begin
      s1_kind_d = KIND_FINITE;
    end
  end

  logic [15:0] s1_upper_q;
  kind_t       s1_kind_q;
  logic        s1_round_up_q;
  logic        s1_nx_q;

  // Stage-1 valid bit: cleared by reset, otherwise follows the input when S1 moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
    end
  end

  // Stage-1 payload capture on an accepted input.
  // NOTE: payload registers carry no reset; they are only observed when the
  // matching valid bit is set, and the valid bits are reset.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_upper_q    <= operand_a[31:16];
      s1_kind_q     <= s1_kind_d;
      s1_round_up_q <= s1_round_up_d;
      s1_nx_q       <= s1_nx_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: apply rounding and build result / flags
  // ---------------------------------------------------------------------
  logic [15:0] rounded;
  logic [15:0] result_d;
  logic [3:0]  flags_d;

  // The carry out of the mantissa ripples into the exponent on purpose: it
  // lands on the next binade, or on infinity from the largest finite value.
  assign rounded = s1_upper_q + {15'd0, s1_round_up_q};

  // Select the output encoding and exception flags for the operand class.
  // NOTE: every output is given a default first so no path leaves a latch.
  always_comb begin
    result_d = 16'h0000;
    flags_d  = 4'b0000;
    unique case (s1_kind_q)
      KIND_NAN: begin
        result_d         = QNAN_BF16;
        flags_d[NV_BIT]  = 1'b1;
      end
      KIND_INF, KIND_ZERO: begin
        result_d = s1_upper_q;
      end
      default: begin
        result_d        = rounded;
        flags_d[OF_BIT] = (rounded[14:7] == 8'hFF);
        flags_d[NX_BIT] = s1_nx_q || flags_d[OF_BIT];
        flags_d[UF_BIT] = flags_d[NX_BIT] && (rounded[14:7] == 8'h00);
      end
    endcase
  end

  logic [15:0] result_q;
  logic [3:0]  flags_q;

  // Stage-2 register: loads when the consumer frees it, holds while stalled.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      result_q   <= 16'h0000;
      flags_q    <= 4'b0000;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

  // ---------------------------------------------------------------------
  // Sticky flag register
  // ---------------------------------------------------------------------
  logic [3:0] fpcsr_q;
  logic [3:0] fpcsr_d;

  // Accumulate on each handshake; a clear drops history but keeps the flags
  // of a result delivered in the same cycle.
  always_comb begin
    fpcsr_d = fpcsr_q;
    if (out_hs) begin
      fpcsr_d = fpcsr_clear ? flags_q : (fpcsr_q | flags_q);
    end else if (fpcsr_clear) begin
      fpcsr_d = 4'b0000;
    end
  end

  // Sticky register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpcsr_q <= 4'b0000;
    end else begin
      fpcsr_q <= fpcsr_d;
    end
  end

  assign fpcsr = fpcsr_q;

endmodule

// File: tb/tb_fp32_to_bf16.sv
// tb_fp32_to_bf16: directed vectors with hand-computed BF16 results.
// The driver pushes the expected response when an input is accepted; an
// independent monitor pops and compares whenever the DUT presents a result.
module tb_fp32_to_bf16;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand_a;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        fpcsr_clear;
  logic [3:0]  fpcsr;

  fp32_to_bf16 dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operand_a   (operand_a),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .flags       (flags),
    .fpcsr_clear (fpcsr_clear),
    .fpcsr       (fpcsr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag encodings {NV, OF, UF, NX}.
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_NX   = 4'b0001;
  localparam logic [3:0] F_UFNX = 4'b0011;
  localparam logic [3:0] F_OFNX = 4'b0101;
  localparam logic [3:0] F_NV   = 4'b1000;

  typedef struct {
    logic [31:0] a;
    logic [15:0] res;
    logic [3:0]  flg;
    int          acc_cyc;
    bit          lat_chk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Present one operand, hold it until accepted, record the expectation.
  task automatic send(input logic [31:0] a, input logic [15:0] r, input logic [3:0] f,
                      input bit lat);
    bit done;
    exp_t e;
    done      = 1'b0;
    in_valid  = 1'b1;
    operand_a = a;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.a = a; e.res = r; e.flg = f; e.acc_cyc = cyc; e.lat_chk = lat;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Wait until every expected result has been delivered.
  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Monitor: compare every presented result with the scoreboard head; while
  // stalled the same head is compared again, which also checks stability.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result %h flags %b with nothing expected",
                   result, flags);
        end else begin
          e = sb[0];
          check($sformatf("result[%h]", e.a), result, e.res);
          check($sformatf("flags[%h]", e.a), flags, e.flg);
          if (out_ready) begin
            // Presented in cycle k, visible two clocks later when unstalled.
            if (e.lat_chk) check($sformatf("latency[%h]", e.a), cyc - e.acc_cyc, 2);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  // Directed vectors run with out_ready held high.
  logic [31:0] vec_a   [13] = '{32'h3F800000, 32'hC0490FDB, 32'h3F808000, 32'h3F818000,
                                32'h3F80FFFF, 32'h7F7FFFFF, 32'h7FA00000, 32'hFFC00001,
                                32'hFF800000, 32'h80000000, 32'h00000001, 32'h00410000,
                                32'h007FC000};
  logic [15:0] vec_r   [13] = '{16'h3F80, 16'hC049, 16'h3F80, 16'h3F82,
                                16'h3F81, 16'h7F80, 16'h7FC0, 16'h7FC0,
                                16'hFF80, 16'h8000, 16'h0000, 16'h0041,
                                16'h0080};
  logic [3:0]  vec_f   [13] = '{F_NONE, F_NX, F_NX, F_NX,
                                F_NX, F_OFNX, F_NV, F_NV,
                                F_NONE, F_NONE, F_UFNX, F_NONE,
                                F_NX};

  initial begin
    int n;
    reset       = 1'b1;
    in_valid    = 1'b0;
    operand_a   = 32'd0;
    out_ready   = 1'b1;
    fpcsr_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_fpcsr", fpcsr, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed vectors, issued back to back.
    for (int i = 0; i < 13; i++) send(vec_a[i], vec_r[i], vec_f[i], 1'b1);
    drain();
    // Sticky OR over everything above: NV | OF | UF | NX.
    check("fpcsr_all", fpcsr, 4'b1111);

    // Backpressure: four inputs against a stalled consumer.
    out_ready = 1'b0;
    fork
      begin
        send(32'h3F800000, 16'h3F80, F_NONE, 1'b0);
        send(32'hC0490FDB, 16'hC049, F_NX,   1'b0);
        send(32'h3F818000, 16'h3F82, F_NX,   1'b0);
        send(32'h00410000, 16'h0041, F_NONE, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        check("bp_in_ready_low", in_ready, 0);
        check("bp_held_items", sb.size(), 2);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Sticky: clear while idle, then NX followed by OF.
    fpcsr_clear = 1'b1;
    @(posedge clk);
    #1 fpcsr_clear = 1'b0;
    check("fpcsr_clear_idle", fpcsr, 0);
    send(32'hC0490FDB, 16'hC049, F_NX,   1'b1);
    send(32'h7F7FFFFF, 16'h7F80, F_OFNX, 1'b1);
    drain();
    check("fpcsr_nx_of", fpcsr, 4'b0101);

    // Clear coinciding with the handshake of an NV result keeps only NV.
    send(32'h7FA00000, 16'h7FC0, F_NV, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("nv_result_seen", out_valid, 1);
    fpcsr_clear = 1'b1;
    @(posedge clk);
    #1 fpcsr_clear = 1'b0;
    check("fpcsr_clear_hs", fpcsr, 4'b1000);
    drain();

    // Reset with both stages full discards everything in flight.
    out_ready = 1'b0;
    send(32'h3F800000, 16'h3F80, F_NONE, 1'b0);
    send(32'h7F7FFFFF, 16'h7F80, F_OFNX, 1'b0);
    check("full_in_ready_low", in_ready, 0);
    reset     = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_fpcsr", fpcsr, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_stale", out_valid, 0);
    send(32'h3F80FFFF, 16'h3F81, F_NX, 1'b1);
    drain();
    check("post_rst_fpcsr", fpcsr, F_NX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
